// File: rtl/simd_adder_pkg.sv
// rtl/simd_adder_pkg.sv - shared types and constants for the SIMD adder pipeline
package simd_adder_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    ADD_SAT = 2'b01,
    SUB     = 2'b10,
    SUB_SAT = 2'b11
  } mode_e;

  localparam int COUNT_W = 16;

  function automatic logic mode_is_sub(input mode_e m);
    return (m == SUB) || (m == SUB_SAT);
  endfunction

  function automatic logic mode_is_sat(input mode_e m);
    return (m == ADD_SAT) || (m == SUB_SAT);
  endfunction

endpackage

// File: rtl/simd_adder_lane.sv
// rtl/simd_adder_lane.sv - combinational single-lane add/sub with overflow and saturation
//
// Ports:
//   a, b  : WIDTH-bit operands
//   mode  : ADD / ADD_SAT / SUB / SUB_SAT
//   c     : WIDTH-bit result (wrapped or saturated)
//   ovf   : overflow of the exact result (carry/borrow unsigned, range overflow signed)
module simd_adder_lane
  import simd_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_e            mode,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  logic [WIDTH:0]   ax;
  logic [WIDTH:0]   bx;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] sat_val;

  always_comb begin
    // One extra bit holds the exact result: zero-extend for unsigned, sign-extend for signed.
    ax = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
    bx = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
    r  = mode_is_sub(mode) ? (ax - bx) : (ax + bx);

    if (SIGNED != 0) begin
      // Exact result no longer fits when the two top bits disagree.
      ovf     = r[WIDTH] ^ r[WIDTH-1];
      // r[WIDTH] is the true sign of the exact result: negative clips to min, else max.
      sat_val = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      // Top bit is carry for add and borrow for subtract.
      ovf     = r[WIDTH];
      sat_val = mode_is_sub(mode) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end

    c = (mode_is_sat(mode) && ovf) ? sat_val : r[WIDTH-1:0];
  end

endmodule

// File: rtl/simd_adder_pipe.sv
// rtl/simd_adder_pipe.sv - multi-lane add/sub with a stall-able valid/ready pipeline
//
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake; mode, a, b sampled at acceptance
//   mode                 : per-transaction operation (see mode_e)
//   a, b                 : LANES packed WIDTH-bit operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready: output handshake
//   c, ovf               : per-lane result and overflow from the last stage
//   done_count           : wrapping count of completed output transfers
module simd_adder_pipe
  import simd_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [LANES*WIDTH-1:0]   a,
  input  logic [LANES*WIDTH-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   c,
  output logic [LANES-1:0]         ovf,
  output logic [COUNT_W-1:0]       done_count
);

  typedef struct packed {
    logic [LANES*WIDTH-1:0] c;
    logic [LANES-1:0]       ovf;
  } stage_t;

  logic [LANES*WIDTH-1:0] c_comb;
  logic [LANES-1:0]       ovf_comb;
  mode_e                  mode_in;

  logic [STAGES:1]        valid;
  stage_t                 pay [1:STAGES];
  logic [STAGES:1]        load;
  logic                   ready_chain;

  assign mode_in = mode_e'(mode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_adder_lane #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_lane (
      .a    (a[i*WIDTH +: WIDTH]),
      .b    (b[i*WIDTH +: WIDTH]),
      .mode (mode_in),
      .c    (c_comb[i*WIDTH +: WIDTH]),
      .ovf  (ovf_comb[i])
    );
  end

  // Ready ripples backwards from the output: a stage may load when it is empty
  // or when everything downstream of it can move this cycle. This is what lets
  // bubbles compact while out_ready is low and keeps full throughput when high.
  always_comb begin
    load        = '0;
    ready_chain = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      load[k]     = !valid[k] || ready_chain;
      ready_chain = load[k];
    end
  end

  assign in_ready  = !reset && load[1];
  assign out_valid = valid[STAGES];
  assign c         = pay[STAGES].c;
  assign ovf       = pay[STAGES].ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      done_count <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        pay[k] <= '0;
      end
    end else begin
      if (load[1]) begin
        valid[1] <= in_valid;
        if (in_valid) begin
          pay[1] <= '{c: c_comb, ovf: ovf_comb};
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (load[k]) begin
          valid[k] <= valid[k-1];
          // Only copy real data so the output registers stay put across bubbles.
          if (valid[k-1]) begin
            pay[k] <= pay[k-1];
          end
        end
      end
      if (out_valid && out_ready) begin
        done_count <= done_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_simd_adder_pipe.sv
// tb/tb_simd_adder_pipe.sv - directed self-checking bench for simd_adder_pipe
module tb_simd_adder_pipe;
  import simd_adder_pkg::*;

  localparam int WIDTH  = 8;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int DW     = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [1:0]    mode;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_ready;

  logic          in_ready_u, out_valid_u;
  logic [DW-1:0] c_u;
  logic [LANES-1:0] ovf_u;
  logic [15:0]   done_u;

  logic          in_ready_s, out_valid_s;
  logic [DW-1:0] c_s;
  logic [LANES-1:0] ovf_s;
  logic [15:0]   done_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simd_adder_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES), .SIGNED(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready), .c(c_u), .ovf(ovf_u),
    .done_count(done_u)
  );

  simd_adder_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .c(c_s), .ovf(ovf_s),
    .done_count(done_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  // Drives one transaction and leaves the bench sampling the cycle its result is visible.
  task automatic run_one(input logic [1:0] m, input logic [DW-1:0] va, input logic [DW-1:0] vb);
    int n;
    mode = m; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready_u && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_u && n < 20) begin tick(); n++; end
    if (!out_valid_u) begin
      errors++; checks++;
      $display("FAIL run_one_timeout: out_valid=%0b required 1", out_valid_u);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; mode = ADD; a = '1; b = '1;
    tick(); tick();
    checks++;
    if (in_ready_u !== 1'b0 || out_valid_u !== 1'b0 || c_u !== '0 || ovf_u !== '0 || done_u !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b c=%h ovf=%b done=%0d required 0 0 0 0 0",
               in_ready_u, out_valid_u, c_u, ovf_u, done_u);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready_u);
    end
  endtask

  task automatic test_unsigned();
    mode_e      md [5] = '{ADD, ADD_SAT, SUB_SAT, SUB, SUB_SAT};
    logic [7:0] va [5] = '{8'd200, 8'd200, 8'd10, 8'd10, 8'd20};
    logic [7:0] vb [5] = '{8'd100, 8'd100, 8'd20, 8'd20, 8'd10};
    logic [7:0] ec [5] = '{8'd44, 8'd255, 8'd0, 8'd246, 8'd10};
    logic       eo [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_one(md[i], {24'd0, va[i]}, {24'd0, vb[i]});
      checks++;
      if (c_u[7:0] !== ec[i] || ovf_u[0] !== eo[i]) begin
        errors++;
        $display("FAIL unsigned_%0d: c=%0d ovf=%0b required c=%0d ovf=%0b", i, c_u[7:0], ovf_u[0], ec[i], eo[i]);
      end
      tick();
    end
  endtask

  task automatic test_signed();
    mode_e      md [3] = '{ADD_SAT, SUB_SAT, ADD};
    logic [7:0] va [3] = '{8'h64, 8'h9C, 8'h05};
    logic [7:0] vb [3] = '{8'h64, 8'h64, 8'hFD};
    logic [7:0] ec [3] = '{8'h7F, 8'h80, 8'h02};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_one(md[i], {24'd0, va[i]}, {24'd0, vb[i]});
      checks++;
      if (c_s[7:0] !== ec[i] || ovf_s[0] !== eo[i]) begin
        errors++;
        $display("FAIL signed_%0d: c=%h ovf=%0b required c=%h ovf=%0b", i, c_s[7:0], ovf_s[0], ec[i], eo[i]);
      end
      tick();
    end
  endtask

  task automatic test_lanes();
    run_one(ADD, 32'h01FF7F00, 32'h01010100);
    checks++;
    if (c_u !== 32'h02008000 || ovf_u !== 4'b0100) begin
      errors++;
      $display("FAIL lanes_unsigned: c=%h ovf=%b required c=02008000 ovf=0100", c_u, ovf_u);
    end
    checks++;
    if (c_s !== 32'h02008000 || ovf_s !== 4'b0010) begin
      errors++;
      $display("FAIL lanes_signed: c=%h ovf=%b required c=02008000 ovf=0010", c_s, ovf_s);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; mode = ADD;
    a = {4{8'd10}}; b = {4{8'd1}};
    #1;
    checks++;
    if (in_ready_u !== 1'b1) begin errors++; $display("FAIL bp_accept0: in_ready=%0b required 1", in_ready_u); end
    tick();
    a = {4{8'd20}}; b = {4{8'd2}};
    #1;
    checks++;
    if (in_ready_u !== 1'b1) begin errors++; $display("FAIL bp_accept1: in_ready=%0b required 1", in_ready_u); end
    tick();
    a = {4{8'd30}}; b = {4{8'd3}};
    #1;
    checks++;
    if (in_ready_u !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%0b required 0", in_ready_u); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready_u !== 1'b0 || out_valid_u !== 1'b1 || c_u !== {4{8'd11}}) begin
        errors++;
        $display("FAIL bp_hold_%0d: in_ready=%0b out_valid=%0b c=%h required 0 1 %h",
                 i, in_ready_u, out_valid_u, c_u, {4{8'd11}});
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_u !== 1'b1) begin errors++; $display("FAIL bp_release_ready: in_ready=%0b required 1", in_ready_u); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid_u !== 1'b1 || c_u !== {4{8'd22}}) begin
      errors++; $display("FAIL bp_out1: out_valid=%0b c=%h required 1 %h", out_valid_u, c_u, {4{8'd22}});
    end
    tick();
    checks++;
    if (out_valid_u !== 1'b1 || c_u !== {4{8'd33}}) begin
      errors++; $display("FAIL bp_out2: out_valid=%0b c=%h required 1 %h", out_valid_u, c_u, {4{8'd33}});
    end
    tick();
    checks++;
    if (out_valid_u !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid=%0b required 0", out_valid_u); end
  endtask

  task automatic test_throughput();
    logic          exp_v;
    logic [7:0]    idx;
    logic [DW-1:0] exp_c;
    int            stalls;
    do_reset();
    out_ready = 1'b1; mode = ADD;
    b = {8'd4, 8'd3, 8'd2, 8'd1};
    stalls = 0;
    for (int t = 1; t <= STAGES + 101; t++) begin
      if (t - 1 < 100) begin
        idx = 8'(t - 1);
        a = {4{idx}};
        in_valid = 1'b1;
        #1;
        if (!in_ready_u) stalls++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (t >= STAGES) && (t <= STAGES + 99);
      checks++;
      if (out_valid_u !== exp_v) begin
        errors++;
        $display("FAIL tp_valid_t%0d: out_valid=%0b required %0b", t, out_valid_u, exp_v);
      end else if (exp_v) begin
        idx = 8'(t - STAGES);
        exp_c = {idx + 8'd4, idx + 8'd3, idx + 8'd2, idx + 8'd1};
        checks++;
        if (c_u !== exp_c) begin
          errors++;
          $display("FAIL tp_data_%0d: c=%h required %h", idx, c_u, exp_c);
        end
      end
    end
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL tp_stalls: stalls=%0d required 0", stalls); end
    checks++;
    if (done_u !== 16'd100) begin errors++; $display("FAIL tp_done_count: done=%0d required 100", done_u); end
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b0; in_valid = 1'b1; mode = ADD;
    a = {4{8'd5}}; b = {4{8'd1}};
    tick();
    a = {4{8'd6}};
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_u !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset: in_ready=%0b required 0", in_ready_u); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid_u !== 1'b0 || done_u !== 16'd0 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL rm_after_reset: out_valid=%0b done=%0d in_ready=%0b required 0 0 1",
               out_valid_u, done_u, in_ready_u);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid_u) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rm_ghost_output: out_valid cycles=%0d required 0", seen); end
    a = {4{8'd7}}; b = {4{8'd8}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid_u !== 1'b0) begin errors++; $display("FAIL rm_early: out_valid=%0b required 0", out_valid_u); end
    for (int i = 1; i < STAGES; i++) tick();
    checks++;
    if (out_valid_u !== 1'b1 || c_u !== {4{8'd15}}) begin
      errors++; $display("FAIL rm_result: out_valid=%0b c=%h required 1 %h", out_valid_u, c_u, {4{8'd15}});
    end
    tick();
    checks++;
    if (done_u !== 16'd1) begin errors++; $display("FAIL rm_done: done=%0d required 1", done_u); end
  endtask

  task automatic test_count_wrap();
    int stalls;
    do_reset();
    out_ready = 1'b1; mode = ADD; a = '0; b = '0;
    stalls = 0;
    for (int t = 1; t <= 65536 + STAGES; t++) begin
      in_valid = (t <= 65536);
      #1;
      if (in_valid && !in_ready_u) stalls++;
      tick();
      if (t == 65535 + STAGES) begin
        checks++;
        if (done_u !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: done=%h required ffff", done_u); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_u !== 16'd0 || out_valid_u !== 1'b0 || stalls != 0) begin
      errors++;
      $display("FAIL wrap_zero: done=%0d out_valid=%0b stalls=%0d required 0 0 0", done_u, out_valid_u, stalls);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = ADD; a = '0; b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_lanes();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
